iir_sample_reader: RTL

IIR_SAMPLE_READER -- requirements
Module: iir_sample_reader

---
 rtl/iir_pkg.sv | 12 +
 rtl/iir_sample_fifo.sv | 86 ++++++++
 rtl/iir_sample_reader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter and its sample reader.
//   DATA_W_DEFAULT : default sample width, matches the filter output y
//   DEPTH_DEFAULT  : default reader FIFO depth
//   sample_t       : signed filter sample at the default width
package iir_pkg;

  localparam int DATA_W_DEFAULT = 12;
  localparam int DEPTH_DEFAULT  = 8;

  typedef logic signed [DATA_W_DEFAULT-1:0] sample_t;

endpackage

// File: rtl/iir_sample_fifo.sv
// Sample storage for iir_sample_reader: DEPTH-entry circular buffer with a
// registered head stage. A sample written into an empty buffer becomes
// visible one cycle after the write, and level counts every stored entry,
// including the one on data_o.
//   clk, rst  : clock, synchronous active-high reset
//   push_i    : write data_i (ignored when full unless pop_i is also set)
//   pop_i     : consume the head (ignored when empty_o)
//   data_i    : sample to write
//   data_o    : head sample, valid when empty_o = 0
//   full_o    : DEPTH entries stored
//   empty_o   : no head sample presented
//   level_o   : occupancy, 0..DEPTH
module iir_sample_fifo
  import iir_pkg::*;
#(
  parameter int  DEPTH  = DEPTH_DEFAULT,
  parameter int  DATA_W = DATA_W_DEFAULT,
  localparam int PW     = $clog2(DEPTH),
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LW-1:0]     level_o
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("iir_sample_fifo: DEPTH must be a power of two, at least 2");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == LW'(DEPTH));
  assign do_pop  = pop_i & valid_q;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + LW'(do_push) - LW'(do_pop);
    // Head stage loads from entries already in memory before this edge, so
    // this cycle's push is not presented until the next cycle.
    valid_d  = (cnt_q != '0) && !(do_pop && cnt_q == LW'(1));
    data_d   = valid_d ? mem_q[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign data_o  = data_q;
  assign full_o  = full;
  assign empty_o = ~valid_q;
  assign level_o = cnt_q;

endmodule

// File: rtl/iir_sample_reader.sv
// Captures IIR filter output samples on each rising edge of the divided
// sample clock and buffers them for a valid/ready consumer.
// Optional feature macro: IIR_READER_PEAK_EN adds a signed peak tracker.
//   clk, rst  : system clock, synchronous active-high reset
//   samp_clk  : divided sample clock, asynchronous to clk
//   y_in      : filter output sample, stable >= 4 clk after samp_clk rises
//   m_data    : head-of-FIFO sample
//   m_valid   : m_data holds a sample
//   m_ready   : consumer accept
//   level     : FIFO occupancy
//   overflow  : sticky flag, a captured sample was dropped (FIFO full)
//   ovf_clr   : single-cycle clear of overflow
//   peak      : (IIR_READER_PEAK_EN) signed max of captured samples
//   peak_clr  : (IIR_READER_PEAK_EN) reload peak to the most negative value
module iir_sample_reader
  import iir_pkg::*;
#(
  parameter int  DEPTH  = DEPTH_DEFAULT,
  parameter int  DATA_W = DATA_W_DEFAULT,
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              samp_clk,
  input  logic [DATA_W-1:0] y_in,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [LW-1:0]     level,
  output logic              overflow,
  input  logic              ovf_clr
`ifdef IIR_READER_PEAK_EN
  ,
  input  logic                     peak_clr,
  output logic signed [DATA_W-1:0] peak
`endif
);

  logic s1_q, s2_q, s3_q;
  logic strobe;
  logic fifo_full, fifo_empty;
  logic pop;
  logic drop;
  logic ovf_q, ovf_d;

  // Synchronizer flops reset high so a samp_clk already high at reset
  // release does not look like a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= samp_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign strobe  = s2_q & ~s3_q;
  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;
  assign drop    = strobe & fifo_full & ~pop;

  iir_sample_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (strobe),
    .pop_i   (pop),
    .data_i  (y_in),
    .data_o  (m_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // A drop in the same cycle as ovf_clr wins.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;

`ifdef IIR_READER_PEAK_EN
  localparam logic signed [DATA_W-1:0] PEAK_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic                     captured;
  logic signed [DATA_W-1:0] peak_q, peak_d;

  assign captured = strobe & ~drop;

  // A capture coinciding with peak_clr restarts tracking from that sample.
  always_comb begin
    peak_d = peak_q;
    if (captured) begin
      if (peak_clr || $signed(y_in) > peak_q) peak_d = $signed(y_in);
    end else if (peak_clr) begin
      peak_d = PEAK_MIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) peak_q <= PEAK_MIN;
    else     peak_q <= peak_d;
  end

  assign peak = peak_q;
`endif

endmodule
